// File: rtl/req_encoder8_3.sv
`default_nettype none
// ============================================================================
// Module  : req_encoder8_3
// Brief   : Registered request encoder. Collapses multi-hot requests into a
//           held index/one-hot grant under valid/ready, with a saturating
//           stall counter. Define RR_ARB_EN for round-robin selection.
// Revision: 1.0 - initial release
// ============================================================================
module req_encoder8_3 #(
    parameter int N_REQ = 8,
    parameter int IDX_W = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] out_onehot,
    output logic             out_multi,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [N_REQ-1:0] c_one     = N_REQ'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t           r_state;
    logic             w_hs;
    logic             w_found;
    logic             w_cap;
    logic             w_multi;
    logic [N_REQ-1:0] w_elig;
    logic [IDX_W-1:0] w_sel;
    logic [IDX_W-1:0] w_cand;

`ifdef RR_ARB_EN
    logic [IDX_W-1:0] r_rr_ptr;
`endif

    assign w_hs    = out_valid & out_ready;
    // On a handshake the just-granted bit is masked so a lingering request is not re-granted.
    assign w_elig  = (r_state == S_HOLD) ? (req & ~out_onehot) : req;
    assign w_multi = |(w_elig & (w_elig - c_one));
    assign w_cap   = en & w_found & ((r_state == S_IDLE) | w_hs);

    always_comb begin
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef RR_ARB_EN
            w_cand = IDX_W'(32'(r_rr_ptr) + k + 1);
`else
            w_cand = IDX_W'(k);
`endif
            if (!w_found && w_elig[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_multi  <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cap) begin
                        r_state   <= S_HOLD;
                        out_valid <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_hs && !w_cap) begin
                        r_state    <= S_IDLE;
                        out_valid  <= 1'b0;
                        out_onehot <= '0;
                    end
                end
            endcase

            if (w_cap) begin
                out_idx    <= w_sel;
                out_onehot <= c_one << w_sel;
                out_multi  <= w_multi;
            end

            if (w_hs) begin
                stall_cnt <= '0;
            end else if (out_valid && !out_ready) begin
                if (stall_cnt != c_cnt_max) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end else begin
                stall_cnt <= '0;
            end
        end
    end

`ifdef RR_ARB_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= IDX_W'(N_REQ - 1);
        end else if (w_hs) begin
            r_rr_ptr <= out_idx;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_req_encoder8_3.sv
`default_nettype none
// ============================================================================
// Module  : tb_req_encoder8_3
// Brief   : Self-checking bench for req_encoder8_3 against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_req_encoder8_3;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [N_REQ-1:0] req;
    logic             out_ready;
    logic             out_valid;
    logic [IDX_W-1:0] out_idx;
    logic [N_REQ-1:0] out_onehot;
    logic             out_multi;
    logic [CNT_W-1:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    req_encoder8_3 #(.N_REQ(N_REQ), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req        (req),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_multi  (out_multi),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: grant = first eligible source found scanning from a start point.
    int               m_rr;
    logic             m_valid;
    int               m_idx;
    logic             m_multi;
    int               m_cnt;
    logic [N_REQ-1:0] m_onehot;
    logic [N_REQ-1:0] m_elig;
    logic             m_hs;
    logic             m_take;
    int               m_start;

    function automatic int pick(input logic [N_REQ-1:0] e, input int start);
        for (int k = 0; k < N_REQ; k++) begin
            if (e[(start + k) % N_REQ]) return (start + k) % N_REQ;
        end
        return 0;
    endfunction

    assign m_onehot = m_valid ? N_REQ'(1 << m_idx) : '0;
    assign m_hs     = m_valid && out_ready;
    assign m_elig   = m_valid ? (req & ~m_onehot) : req;
    assign m_take   = en && (m_elig != 0) && (!m_valid || m_hs);
`ifdef RR_ARB_EN
    assign m_start  = (m_rr + 1) % N_REQ;
`else
    assign m_start  = 0;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_multi <= 1'b0;
            m_cnt   <= 0;
            m_rr    <= N_REQ - 1;
        end else begin
            if (m_take) begin
                m_valid <= 1'b1;
                m_idx   <= pick(m_elig, m_start);
                m_multi <= ($countones(m_elig) >= 2);
            end else if (m_hs) begin
                m_valid <= 1'b0;
            end
            if (m_hs)                        m_cnt <= 0;
            else if (m_valid && !out_ready)  m_cnt <= (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
            else                             m_cnt <= 0;
            if (m_hs) m_rr <= m_idx;
        end
    end

    always @(negedge clk) begin
        chk("cmp_valid",  32'(out_valid),  32'(m_valid));
        chk("cmp_idx",    32'(out_idx),    32'(m_idx));
        chk("cmp_onehot", 32'(out_onehot), 32'(m_onehot));
        chk("cmp_multi",  32'(out_multi),  32'(m_multi));
        chk("cmp_stall",  32'(stall_cnt),  32'(m_cnt));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; req = '0; out_ready = 1'b0;
        #1;
        chk("reset_all", {out_valid, 5'(out_idx), out_onehot, out_multi, 8'(stall_cnt)}, 32'h0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Two requesters; source 2 drops once granted.
        en = 1'b1; out_ready = 1'b1; req = 8'h24;
        tick();
        chk("t1_c1_valid",  32'(out_valid), 32'd1);
        chk("t1_c1_idx",    32'(out_idx), 32'd2);
        chk("t1_c1_onehot", 32'(out_onehot), 32'h04);
        chk("t1_c1_multi",  32'(out_multi), 32'd1);
        req = 8'h20;
        tick();
        chk("t1_c2_idx",    32'(out_idx), 32'd5);
        chk("t1_c2_onehot", 32'(out_onehot), 32'h20);
        chk("t1_c2_multi",  32'(out_multi), 32'd0);
        req = 8'h00;
        tick();
        chk("t1_c3_valid",  32'(out_valid), 32'd0);

        // Stall counting and saturation.
        out_ready = 1'b0; req = 8'h80;
        tick();
        repeat (5) tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_idx",   32'(out_idx), 32'd7);
        chk("t2_stall", 32'(stall_cnt), 32'd5);
        out_ready = 1'b1; req = 8'h00;
        tick();
        chk("t2_rel_valid", 32'(out_valid), 32'd0);
        chk("t2_rel_stall", 32'(stall_cnt), 32'd0);
        out_ready = 1'b0; req = 8'h80;
        tick();
        repeat (10) tick();
        chk("t2_sat", 32'(stall_cnt), 32'(CMAX));
        out_ready = 1'b1; req = 8'h00;
        tick();

        // Enable gating.
        en = 1'b0; out_ready = 1'b0; req = 8'hFF;
        tick(); tick();
        chk("t3_en0_valid", 32'(out_valid), 32'd0);
        en = 1'b1;
        tick();
        chk("t3_grant", 32'(out_valid), 32'd1);
        en = 1'b0;
        repeat (3) tick();
        chk("t3_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        chk("t3_drop_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-hold.
        en = 1'b1; out_ready = 1'b0; req = 8'h20;
        tick();
        chk("t5_idx", 32'(out_idx), 32'd5);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_clear", {out_valid, 5'(out_idx), out_onehot, out_multi, 8'(stall_cnt)}, 32'h0);
        tick();
        rst = 1'b0; req = 8'h00;
        tick();
        chk("t5_idle_valid", 32'(out_valid), 32'd0);
        chk("t5_idle_idx",   32'(out_idx), 32'd0);

        // Constant full request, back-to-back grants.
        en = 1'b1; out_ready = 1'b1; req = 8'hFF;
        for (int n = 0; n < 10; n++) begin
            tick();
            chk("t4_valid", 32'(out_valid), 32'd1);
`ifdef RR_ARB_EN
            chk("t4_idx", 32'(out_idx), 32'(n % 8));
`else
            chk("t4_idx", 32'(out_idx), 32'(n % 2));
`endif
        end

        // Randomized traffic.
        for (int blk = 0; blk < 40; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(5, 95);
            for (int c = 0; c < 75; c++) begin
                case ($urandom_range(0, 3))
                    0: req = N_REQ'($urandom);
                    1: req = N_REQ'(1 << $urandom_range(0, N_REQ - 1));
                    2: req = '0;
                    default: req = N_REQ'($urandom) | N_REQ'($urandom);
                endcase
                en        = ($urandom_range(0, 7) != 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                rst       = ($urandom_range(0, 299) == 0);
                tick();
            end
        end
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
